// File: rtl/mux_scan_reg.sv
// Registered NCH:1 channel selector with valid/ready output and auto-scan.
// Ports: clk, rst_n, in_bus, mode, sel, req_valid/req_ready, start, out_*, busy.
module mux_scan_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 16,
  parameter int SELW  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_bus,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 start,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  if (NCH < 2 || SELW != $clog2(NCH)) begin : g_bad_param
    $error("mux_scan_reg: need NCH>=2 and SELW==clog2(NCH)");
  end

  typedef enum logic [0:0] {
    IDLE,
    SCAN
  } state_t;

  state_t state, state_n;

  logic [SELW-1:0]  cnt, cnt_n;
  logic [WIDTH-1:0] chan [NCH];

  logic             free;
  logic             ld;
  logic [SELW-1:0]  ld_ch;
  logic             ld_last;
  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] cnt_data;

  // channel 0 lives in the MSB slice
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign chan[i] = in_bus[(NCH-1-i)*WIDTH +: WIDTH];
  end

  // Compare-based lookup: a sel beyond NCH-1 matches nothing and reads 0.
  always_comb begin
    sel_data = '0;
    cnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SELW'(i)) sel_data = chan[i];
      if (cnt == SELW'(i)) cnt_data = chan[i];
    end
  end

  assign free = !out_valid || out_ready;
  assign busy = (state == SCAN);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    req_ready = 1'b0;
    ld        = 1'b0;
    ld_ch     = '0;
    ld_last   = 1'b0;
    ld_data   = '0;
    unique case (state)
      IDLE: begin
        req_ready = free;
        if (free) begin
          if (mode && start) begin
            ld      = 1'b1;
            ld_ch   = '0;
            ld_data = chan[0];
            cnt_n   = SELW'(1);
            state_n = SCAN;
          end else if (!mode && req_valid) begin
            ld      = 1'b1;
            ld_ch   = sel;
            ld_data = sel_data;
          end
        end
      end
      SCAN: begin
        if (free) begin
          ld      = 1'b1;
          ld_ch   = cnt;
          ld_data = cnt_data;
          if (cnt == SELW'(NCH-1)) begin
            ld_last = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + SELW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (ld) begin
      out_data  <= ld_data;
      out_ch    <= ld_ch;
      out_last  <= ld_last;
      out_valid <= 1'b1;
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed self-checking bench for mux_scan_reg.
// Covers the 16x8 default build and a 5x32 variant.
module tb_mux_scan_reg;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic [127:0] in_bus = '0;
  logic         mode = 1'b0;
  logic [3:0]   sel = '0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         start = 1'b0;
  logic [7:0]   out_data;
  logic [3:0]   out_ch;
  logic         out_last;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;

  logic [159:0] b_in_bus = '0;
  logic         b_mode = 1'b0;
  logic [2:0]   b_sel = '0;
  logic         b_req_valid = 1'b0;
  logic         b_req_ready;
  logic         b_start = 1'b0;
  logic [31:0]  b_out_data;
  logic [2:0]   b_out_ch;
  logic         b_out_last;
  logic         b_out_valid;
  logic         b_out_ready = 1'b1;
  logic         b_busy;

  int nchk = 0;
  int nerr = 0;

  mux_scan_reg #(.WIDTH(8), .NCH(16), .SELW(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .mode(mode),
    .sel(sel), .req_valid(req_valid), .req_ready(req_ready),
    .start(start), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  mux_scan_reg #(.WIDTH(32), .NCH(5), .SELW(3)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_bus(b_in_bus), .mode(b_mode),
    .sel(b_sel), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .start(b_start), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_last(b_out_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ramp_bus();
    for (int i = 0; i < 16; i++) in_bus[(15-i)*8 +: 8] = 8'h10 + 8'(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nb;
    // reset state
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_b_valid", b_out_valid, 0);
    step();
    rst_n = 1'b1;
    step();

    // direct walk: one-hot channel k
    out_ready = 1'b1;
    req_valid = 1'b1;
    mode = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_bus = 128'h1 << ((15 - k) * 8);
      sel = 4'(k);
      check("walk_rdy", req_ready, 1);
      step();
      check("walk_valid", out_valid, 1);
      check("walk_data", out_data, 8'h01);
      check("walk_ch", out_ch, k);
      check("walk_last", out_last, 0);
      sel = 4'((k + 1) % 16);
      step();
      check("walk_off_data", out_data, 8'h00);
      check("walk_off_ch", out_ch, (k + 1) % 16);
    end

    // direct stall
    in_bus = '0;
    in_bus[(15-3)*8 +: 8] = 8'hA5;
    sel = 4'd3;
    step();
    check("stall_load", out_data, 8'hA5);
    out_ready = 1'b0;
    sel = 4'd5;
    for (int c = 0; c < 4; c++) begin
      in_bus = {4{$urandom()}};
      #1;
      check("stall_rdy", req_ready, 0);
      step();
      check("stall_data", out_data, 8'hA5);
      check("stall_ch", out_ch, 3);
      check("stall_valid", out_valid, 1);
    end
    in_bus = '0;
    in_bus[(15-5)*8 +: 8] = 8'h5A;
    out_ready = 1'b1;
    #1;
    check("release_rdy", req_ready, 1);
    step();
    check("release_data", out_data, 8'h5A);
    check("release_ch", out_ch, 5);
    req_valid = 1'b0;
    step();
    check("idle_clear", out_valid, 0);

    // scan sweep, no backpressure
    ramp_bus();
    mode = 1'b1;
    start = 1'b1;
    #1;
    check("scan_start_rdy", req_ready, 1);
    step();
    start = 1'b0;
    for (int b = 0; b < 16; b++) begin
      check("scan_valid", out_valid, 1);
      check("scan_data", out_data, 8'h10 + b);
      check("scan_ch", out_ch, b);
      check("scan_last", out_last, b == 15);
      check("scan_busy", busy, b < 15);
      check("scan_rdy", req_ready, b == 15);
      step();
    end
    check("scan_done_valid", out_valid, 0);

    // scan with backpressure 1,0,0,1,...
    nb = 0;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 200 && nb < 16; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      #1;
      if (out_valid && out_ready) begin
        check("bp_ch", out_ch, nb);
        check("bp_data", out_data, 8'h10 + nb);
        check("bp_last", out_last, nb == 15);
        nb++;
      end
      step();
    end
    check("bp_beats", nb, 16);
    check("bp_busy", busy, 0);

    // reset mid-sweep at beat 6
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    check("pre_rst_ch", out_ch, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ch", out_ch, 0);
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_ch", out_ch, 0);
    check("restart_data", out_data, 8'h10);
    check("restart_busy", busy, 1);
    for (int c = 0; c < 40 && busy; c++) step();
    check("restart_end", busy, 0);
    mode = 1'b0;

    // 5-channel, 32-bit variant
    for (int i = 0; i < 5; i++) b_in_bus[(4-i)*32 +: 32] = 32'hC0DE0000 + i;
    b_mode = 1'b1;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int b = 0; b < 5; b++) begin
      check("v5_valid", b_out_valid, 1);
      check("v5_ch", b_out_ch, b);
      check("v5_data", b_out_data, 32'hC0DE0000 + b);
      check("v5_last", b_out_last, b == 4);
      step();
    end
    check("v5_done", b_busy, 0);
    b_mode = 1'b0;
    b_req_valid = 1'b1;
    b_sel = 3'd6;
    step();
    check("v5_sel6_data", b_out_data, 0);
    check("v5_sel6_ch", b_out_ch, 6);
    check("v5_sel6_valid", b_out_valid, 1);
    b_sel = 3'd2;
    step();
    check("v5_sel2_data", b_out_data, 32'hC0DE0002);
    b_req_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
